hack_cpu_mc: RTL and testbench

//  Parametrised multicycle successor of the Hack CPU. It drives separate instruction and data

---
 rtl/hack_pkg.sv | 32 +++
 rtl/hack_cpu_mc_if.sv | 34 +++
 rtl/hack_alu_p.sv | 36 +++
 rtl/hack_cpu_mc.sv | 155 +++++++++++++++
 tb/tb_hack_cpu_mc.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the multicycle Hack CPU: FSM states, instruction
// field positions and jump encodings.
package hack_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_MREAD,
      S_EXEC,
      S_MWRITE,
      S_HALT
   } cpu_state_t;

   // C-instruction field positions (fixed, independent of DATA_W)
   localparam int A_BIT   = 12;  // 1 = ALU y operand is M
   localparam int C_MSB   = 11;  // zx nx zy ny f no
   localparam int C_LSB   = 6;
   localparam int D_A_BIT = 5;   // destination A
   localparam int D_D_BIT = 4;   // destination D
   localparam int D_M_BIT = 3;   // destination M

   // Jump field: one bit per ALU result class
   localparam int J_LT_BIT = 2;
   localparam int J_EQ_BIT = 1;
   localparam int J_GT_BIT = 0;
   localparam logic [2:0] J_JMP = 3'b111;

   // Jump decision from the jump field and the ALU flags
   function automatic logic jump_take(input logic [2:0] j, input logic ng, input logic zr);
      return (j[J_LT_BIT] & ng) | (j[J_EQ_BIT] & zr) | (j[J_GT_BIT] & ~ng & ~zr);
   endfunction

endpackage

// File: rtl/hack_cpu_mc_if.sv
// Instruction and data memory ports of the multicycle Hack CPU. Both sides
// use a request/response handshake so memories may insert wait states.
interface hack_cpu_mc_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 15
);

   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_valid;
   logic [DATA_W-1:0] imem_data;

   logic              dmem_req;
   logic              dmem_we;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic [DATA_W-1:0] dmem_rdata;
   logic              dmem_ack;

   modport master (
      output imem_req, imem_addr,
      input  imem_valid, imem_data,
      output dmem_req, dmem_we, dmem_addr, dmem_wdata,
      input  dmem_rdata, dmem_ack
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_valid, imem_data,
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
      output dmem_rdata, dmem_ack
   );

endinterface

// File: rtl/hack_alu_p.sv
// Combinational Hack ALU, generic width: zero/negate each operand, add or
// AND, optionally negate the result; reports zero and negative flags.
module hack_alu_p #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] x,
   input  logic [DATA_W-1:0] y,
   input  logic              zx,
   input  logic              nx,
   input  logic              zy,
   input  logic              ny,
   input  logic              f,
   input  logic              no,
   output logic [DATA_W-1:0] out,
   output logic              zr,
   output logic              ng
);

   logic [DATA_W-1:0] xa, ya, res;

   // Operand conditioning, function select and flag generation; sums wrap
   always_comb begin
      xa = x;
      if (zx) xa = '0;
      if (nx) xa = ~xa;
      ya = y;
      if (zy) ya = '0;
      if (ny) ya = ~ya;
      res = f ? (xa + ya) : (xa & ya);
      if (no) res = ~res;
      out = res;
      zr  = (res == '0);
      ng  = res[DATA_W-1];
   end

endmodule

// File: rtl/hack_cpu_mc.sv
// Multicycle Hack CPU with separate handshaked instruction and data ports.
// FETCH -> [MREAD] -> EXEC -> [MWRITE] -> commit; an unconditional jump onto
// itself (or onto the A-instruction just before it) parks the core in HALT.
// DATA_W must be >= 16 and ADDR_W <= DATA_W-1.
module hack_cpu_mc
   import hack_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 15,
   parameter int HALT_DETECT = 1
) (
   input  logic              clk,
   input  logic              reset,
   hack_cpu_mc_if.master     bus,
   output logic [ADDR_W-1:0] pc,
   output logic              retire,
   output logic              halted
);

   cpu_state_t state, next_state;

   logic [DATA_W-1:0] ir, a_reg, d_reg, mdr, wdata_q;
   logic [ADDR_W-1:0] wr_addr_q, last_pc_q;
   logic              take_q, halt_q, last_a_q;

   // Decode of the latched instruction
   logic       is_c, sel_m;
   logic [2:0] jbits;
   assign is_c  = ir[DATA_W-1];
   assign sel_m = ir[A_BIT];
   assign jbits = ir[2:0];

   // Decode of the word arriving on the fetch port, used to pick the next state
   logic f_needs_m;
   assign f_needs_m = bus.imem_data[DATA_W-1] & bus.imem_data[A_BIT];

   logic [DATA_W-1:0] alu_out;
   logic              alu_zr, alu_ng;

   hack_alu_p #(.DATA_W(DATA_W)) u_alu (
      .x  (d_reg),
      .y  (sel_m ? mdr : a_reg),
      .zx (ir[C_MSB]),
      .nx (ir[C_MSB-1]),
      .zy (ir[C_MSB-2]),
      .ny (ir[C_MSB-3]),
      .f  (ir[C_LSB+1]),
      .no (ir[C_LSB]),
      .out(alu_out),
      .zr (alu_zr),
      .ng (alu_ng)
   );

   // Jump target is the A value before this instruction writes A
   logic [ADDR_W-1:0] tgt, pc_prev;
   logic              take_c, halt_c;
   assign tgt     = a_reg[ADDR_W-1:0];
   assign pc_prev = pc - ADDR_W'(1);
   assign take_c  = is_c & jump_take(jbits, alu_ng, alu_zr);
   assign halt_c  = (HALT_DETECT != 0) && is_c && (jbits == J_JMP) &&
                    ((tgt == pc) || ((tgt == pc_prev) && last_a_q && (last_pc_q == pc_prev)));

   // Commit decision: straight from EXEC, or from the values held over MWRITE
   logic              commit;
   logic              commit_take, commit_halt;
   logic [ADDR_W-1:0] commit_target;
   assign commit_take   = (state == S_EXEC) ? take_c : take_q;
   assign commit_halt   = (state == S_EXEC) ? halt_c : halt_q;
   assign commit_target = (state == S_EXEC) ? tgt    : wr_addr_q;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) state <= S_FETCH;
      else       state <= next_state;
   end

   // Next-state and memory-port control
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
      next_state    = state;
      commit        = 1'b0;
      bus.imem_req  = 1'b0;
      bus.dmem_req  = 1'b0;
      bus.dmem_we   = 1'b0;
      bus.dmem_addr = wr_addr_q;
      case (state)
         S_FETCH: begin
            // Gated so no fetch is requested while reset is held
            bus.imem_req = ~reset;
            if (bus.imem_valid) next_state = f_needs_m ? S_MREAD : S_EXEC;
         end
         S_MREAD: begin
            bus.dmem_req  = 1'b1;
            bus.dmem_addr = tgt;
            if (bus.dmem_ack) next_state = S_EXEC;
         end
         S_EXEC: begin
            if (is_c && ir[D_M_BIT]) next_state = S_MWRITE;
            else                     commit     = 1'b1;
         end
         S_MWRITE: begin
            bus.dmem_req = 1'b1;
            bus.dmem_we  = 1'b1;
            if (bus.dmem_ack) commit = 1'b1;
         end
         S_HALT: next_state = S_HALT;
         default: next_state = S_FETCH;
      endcase
      if (commit) next_state = commit_halt ? S_HALT : S_FETCH;
   end

   assign bus.imem_addr  = pc;
   assign bus.dmem_wdata = wdata_q;
   assign retire         = commit;
   assign halted         = (state == S_HALT);

   // Datapath registers: IR/MDR capture, EXEC writeback, PC update at commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc        <= '0;
         ir        <= '0;
         a_reg     <= '0;
         d_reg     <= '0;
         mdr       <= '0;
         wdata_q   <= '0;
         wr_addr_q <= '0;
         take_q    <= 1'b0;
         halt_q    <= 1'b0;
         last_a_q  <= 1'b0;
         last_pc_q <= '0;
      end else begin
         if (state == S_FETCH && bus.imem_valid) ir  <= bus.imem_data;
         if (state == S_MREAD && bus.dmem_ack)   mdr <= bus.dmem_rdata;
         if (state == S_EXEC) begin
            if (!is_c) begin
               a_reg <= {1'b0, ir[DATA_W-2:0]};
            end else begin
               if (ir[D_A_BIT]) a_reg <= alu_out;
               if (ir[D_D_BIT]) d_reg <= alu_out;
               wdata_q   <= alu_out;
               wr_addr_q <= tgt;
               take_q    <= take_c;
               halt_q    <= halt_c;
            end
         end
         if (commit) begin
            pc        <= commit_take ? commit_target : pc + ADDR_W'(1);
            last_a_q  <= ~is_c;
            last_pc_q <= pc;
         end
      end
   end

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Directed bench for hack_cpu_mc: ROM/RAM models with configurable data-port
// wait states, hand-assembled programs and hand-computed results.
module tb_hack_cpu_mc;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 15;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic reset1 = 1'b1;
   always #5 clk = ~clk;

   hack_cpu_mc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus0 ();
   hack_cpu_mc_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();

   logic [ADDR_W-1:0] pc0, pc1;
   logic              retire0, retire1, halted0, halted1;

   hack_cpu_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HALT_DETECT(1)) dut0 (
      .clk(clk), .reset(reset), .bus(bus0), .pc(pc0), .retire(retire0), .halted(halted0)
   );

   hack_cpu_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .HALT_DETECT(0)) dut1 (
      .clk(clk), .reset(reset1), .bus(bus1), .pc(pc1), .retire(retire1), .halted(halted1)
   );

   logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

   // dut0: instruction port always valid (exercises "valid ignored outside FETCH")
   int dwait = 0;
   int dcnt;
   assign bus0.imem_valid = 1'b1;
   assign bus0.imem_data  = rom[bus0.imem_addr];
   assign bus0.dmem_rdata = ram[bus0.dmem_addr];
   assign bus0.dmem_ack   = bus0.dmem_req && (dcnt >= dwait);

   // dut1: zero-wait on both ports
   assign bus1.imem_valid = bus1.imem_req;
   assign bus1.imem_data  = rom[bus1.imem_addr];
   assign bus1.dmem_rdata = '0;
   assign bus1.dmem_ack   = bus1.dmem_req;

   int ret_cnt, cyc, last_ret_cyc, wr_cnt, wait_cnt, halt_req_cnt, ret_cnt1;
   logic [31:0] wr_addr_log [0:7];
   logic [31:0] wr_data_log [0:7];
   logic [31:0] wr_wait_log [0:7];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         dcnt <= 0; ret_cnt <= 0; cyc <= 0; last_ret_cyc <= 0;
         wr_cnt <= 0; wait_cnt <= 0; halt_req_cnt <= 0;
      end else begin
         cyc <= cyc + 1;
         if (retire0) begin
            ret_cnt      <= ret_cnt + 1;
            last_ret_cyc <= cyc + 1;
         end
         if (bus0.dmem_req) begin
            if (bus0.dmem_ack) begin
               dcnt <= 0;
               if (bus0.dmem_we) begin
                  ram[bus0.dmem_addr] <= bus0.dmem_wdata;
                  if (wr_cnt < 8) begin
                     wr_addr_log[wr_cnt] <= 32'(bus0.dmem_addr);
                     wr_data_log[wr_cnt] <= 32'(bus0.dmem_wdata);
                     wr_wait_log[wr_cnt] <= 32'(dcnt);
                  end
                  wr_cnt <= wr_cnt + 1;
               end
            end else begin
               dcnt     <= dcnt + 1;
               wait_cnt <= wait_cnt + 1;
            end
         end else begin
            dcnt <= 0;
         end
         if (halted0 && (bus0.imem_req || bus0.dmem_req)) halt_req_cnt <= halt_req_cnt + 1;
      end
   end

   always @(posedge clk or posedge reset1) begin
      if (reset1)       ret_cnt1 <= 0;
      else if (retire1) ret_cnt1 <= ret_cnt1 + 1;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = '0;
   endtask

   task automatic start_test();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic run_until(input int n, input int budget);
      int k;
      k = 0;
      while (ret_cnt < n && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      check($sformatf("reach_retire_%0d", n), 32'(ret_cnt >= n), 32'd1);
   endtask

   initial begin
      // ---- reset state ----
      clear_rom();
      rom[0] = 16'h0005;  // @5
      rom[1] = 16'hEC10;  // D=A
      rom[2] = 16'h0064;  // @100
      rom[3] = 16'hE308;  // M=D
      repeat (2) @(negedge clk);
      check("rst_pc",       32'(pc0), 32'd0);
      check("rst_halted",   32'(halted0), 32'd0);
      check("rst_retire",   32'(retire0), 32'd0);
      check("rst_imem_req", 32'(bus0.imem_req), 32'd0);
      check("rst_dmem_req", 32'(bus0.dmem_req), 32'd0);
      check("rst_dmem_we",  32'(bus0.dmem_we), 32'd0);

      // ---- T1: @5; D=A; @100; M=D, zero-wait ----
      reset = 1'b0;
      run_until(4, 100);
      check("t1_pc",      32'(pc0), 32'd4);
      check("t1_cycles",  32'(last_ret_cyc), 32'd9);
      check("t1_wr_cnt",  32'(wr_cnt), 32'd1);
      check("t1_wr_addr", wr_addr_log[0], 32'd100);
      check("t1_wr_data", wr_data_log[0], 32'd5);

      // ---- T2: @7; AM=A+1; M=A; @7; D=M+1; @30; M=D, 3 wait states ----
      clear_rom();
      rom[0] = 16'h0007;  // @7
      rom[1] = 16'hEDE8;  // AM=A+1  -> M[7]=8, A=8
      rom[2] = 16'hEC08;  // M=A     -> M[8]=8
      rom[3] = 16'h0007;  // @7
      rom[4] = 16'hFDD0;  // D=M+1   -> D=9
      rom[5] = 16'h001E;  // @30
      rom[6] = 16'hE308;  // M=D     -> M[30]=9
      dwait = 3;
      start_test();
      run_until(7, 300);
      check("t2_wr_cnt",  32'(wr_cnt), 32'd3);
      check("t2_wr0_addr", wr_addr_log[0], 32'd7);
      check("t2_wr0_data", wr_data_log[0], 32'd8);
      check("t2_wr0_wait", wr_wait_log[0], 32'd3);
      check("t2_wr1_addr", wr_addr_log[1], 32'd8);
      check("t2_wr1_data", wr_data_log[1], 32'd8);
      check("t2_wr2_addr", wr_addr_log[2], 32'd30);
      check("t2_wr2_data", wr_data_log[2], 32'd9);
      check("t2_waits",    32'(wait_cnt), 32'd12);
      check("t2_cycles",   32'(last_ret_cyc), 32'd30);
      check("t2_pc",       32'(pc0), 32'd7);

      // ---- T3: jump conditions with D=-1, A=20 ----
      clear_rom();
      rom[0]  = 16'h0014;  // @20
      rom[1]  = 16'hEE90;  // D=-1
      rom[2]  = 16'hE301;  // D;JGT  not taken
      rom[3]  = 16'hE302;  // D;JEQ  not taken
      rom[4]  = 16'hE304;  // D;JLT  taken -> 20
      rom[20] = 16'hE7D0;  // D=D+1
      rom[21] = 16'hE302;  // D;JEQ  taken first time (D=0), not second (D=1)
      dwait = 0;
      start_test();
      run_until(3, 50);
      check("t3_jgt_pc", 32'(pc0), 32'd3);
      run_until(4, 50);
      check("t3_jeq_pc", 32'(pc0), 32'd4);
      run_until(5, 50);
      check("t3_jlt_pc", 32'(pc0), 32'd20);
      run_until(7, 50);
      check("t3_jeq_zero_pc", 32'(pc0), 32'd20);
      run_until(9, 50);
      check("t3_jeq_one_pc", 32'(pc0), 32'd22);
      check("t3_no_writes", 32'(wr_cnt), 32'd0);

      // ---- T4: pc wrap at 32767 ----
      clear_rom();
      rom[0]     = 16'h7FFF;  // @32767
      rom[1]     = 16'hEA87;  // 0;JMP
      rom[32767] = 16'hEC10;  // D=A
      start_test();
      run_until(2, 50);
      check("t4_pc_top", 32'(pc0), 32'd32767);
      run_until(3, 50);
      check("t4_pc_wrap", 32'(pc0), 32'd0);
      check("t4_not_halted", 32'(halted0), 32'd0);

      // ---- T5: @9 at 9, 0;JMP at 10; dut1 has halt detection off ----
      clear_rom();
      rom[9]  = 16'h0009;
      rom[10] = 16'hEA87;
      reset  = 1'b1;
      reset1 = 1'b1;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      reset1 = 1'b0;
      run_until(10, 100);
      check("t5_not_yet_halted", 32'(halted0), 32'd0);
      check("t5_pc_at_jmp", 32'(pc0), 32'd10);
      run_until(11, 100);
      check("t5_halted", 32'(halted0), 32'd1);
      check("t5_pc_halt", 32'(pc0), 32'd9);
      repeat (20) @(posedge clk);
      #1;
      check("t5_retires_frozen", 32'(ret_cnt), 32'd11);
      check("t5_no_req_in_halt", 32'(halt_req_cnt), 32'd0);
      check("t5_halted_sticky", 32'(halted0), 32'd1);
      check("t5_nodetect_halted", 32'(halted1), 32'd0);
      check("t5_nodetect_loops", 32'(ret_cnt1 >= 15), 32'd1);
      reset1 = 1'b1;

      // ---- T6: 0;JMP onto itself ----
      clear_rom();
      rom[0] = 16'h0001;  // @1
      rom[1] = 16'hEA87;  // 0;JMP
      start_test();
      run_until(2, 50);
      check("t6_halted", 32'(halted0), 32'd1);
      check("t6_pc", 32'(pc0), 32'd1);
      repeat (5) @(posedge clk);
      #1;
      check("t6_retires_frozen", 32'(ret_cnt), 32'd2);

      // ---- T7: reset during an MREAD wait ----
      clear_rom();
      rom[0] = 16'h0003;  // @3
      rom[1] = 16'hFC10;  // D=M
      dwait = 5;
      start_test();
      for (int k = 0; k < 20 && !bus0.dmem_req; k++) begin
         @(posedge clk);
         #1;
      end
      check("t7_mread_seen", 32'(bus0.dmem_req), 32'd1);
      @(posedge clk);
      #1;
      check("t7_mread_wait", 32'(bus0.dmem_req), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("t7_rst_dmem_req", 32'(bus0.dmem_req), 32'd0);
      check("t7_rst_imem_req", 32'(bus0.imem_req), 32'd0);
      check("t7_rst_pc", 32'(pc0), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("t7_refetch_req", 32'(bus0.imem_req), 32'd1);
      check("t7_refetch_addr", 32'(bus0.imem_addr), 32'd0);
      run_until(1, 20);
      check("t7_pc_after", 32'(pc0), 32'd1);
      check("t7_no_writes", 32'(wr_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
